// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for a shared-memory, shared-ALU RV32I subset datapath (lw/sw/R-type/beq).
// Moore controls are registered alongside the state; only handshake/branch strobes use live inputs.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_req,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAdr   = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecuteR = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9
    } state_e;

    typedef struct packed {
        logic       adr_src;
        logic       mem_req;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
    } ctrl_t;

    // Control word for a given state; op only matters in MEMADR (lw vs sw immediate format).
    function automatic ctrl_t moore_ctrl(input state_e s, input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            StDecode: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            StMemAdr: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = (opc == OpStore) ? 2'b01 : 2'b00;
            end
            StMemRead: begin
                c.adr_src = 1'b1;
                c.mem_req = 1'b1;
            end
            StMemWb: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            StMemWrite: begin
                c.adr_src   = 1'b1;
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
            end
            StExecuteR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            StAluWb: begin
                c.reg_write = 1'b1;
            end
            StBeq: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             op_illegal;

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        op_illegal = 1'b0;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpBranch:        state_d = StBeq;
                    default: begin
                        state_d    = StFetch;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr:  state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemRead: if (mem_ready) state_d = StMemWb;
            StMemWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StMemWrite: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StExecuteR: state_d = StAluWb;
            StAluWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StBeq: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_ctrl(state_d, op);
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Fetch loads PC and IR together on the ready cycle; BEQ loads PC only when taken.
    assign ir_write   = (state_q == StFetch) && mem_ready;
    assign pc_write   = ((state_q == StFetch) && mem_ready) || ((state_q == StBeq) && zero);
    assign adr_src    = ctrl_q.adr_src;
    assign mem_req    = ctrl_q.mem_req;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign result_src = ctrl_q.result_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign imm_src    = ctrl_q.imm_src;
    assign illegal_op = op_illegal;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state/control vectors for each instruction class.
module tb_multicycle_controller;

    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b0010011;

    // {state, pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op}
    localparam logic [20:0] V_IDLE       = 21'd0;
    localparam logic [20:0] V_FETCH_RDY  = {4'd1, 6'b110100, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] V_FETCH_WAIT = {4'd1, 6'b000100, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] V_DECODE     = {4'd2, 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 1'b0};
    localparam logic [20:0] V_DECODE_ILL = {4'd2, 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1};
    localparam logic [20:0] V_MEMADR_LW  = {4'd3, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] V_MEMADR_SW  = {4'd3, 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 1'b0};
    localparam logic [20:0] V_MEMREAD    = {4'd4, 6'b001100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] V_MEMWB      = {4'd5, 6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] V_MEMWRITE   = {4'd6, 6'b001110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] V_EXEC       = {4'd7, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [20:0] V_ALUWB      = {4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [20:0] V_BEQ_T      = {4'd9, 6'b100000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [20:0] V_BEQ_N      = {4'd9, 6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, illegal_op;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;
    logic [20:0]      obs;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal_op (illegal_op),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign obs = {state, pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op};

    task automatic test_reset();
        rst = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== V_IDLE) begin
            $display("FAIL reset_outputs: got %h expected %h", obs, V_IDLE); n_err++;
        end
        n_cmp++;
        if (retired !== 4'd0) begin
            $display("FAIL reset_retired: got %0d expected 0", retired); n_err++;
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== V_IDLE) begin
            $display("FAIL idle_after_release: got %h expected %h", obs, V_IDLE); n_err++;
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== V_FETCH_WAIT) begin
            $display("FAIL first_fetch: got %h expected %h", obs, V_FETCH_WAIT); n_err++;
        end
    endtask

    task automatic test_rtype();
        logic [20:0] ev [4];
        ev = '{V_FETCH_RDY, V_DECODE, V_EXEC, V_ALUWB};
        op = OP_R; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (obs !== ev[i]) begin
                $display("FAIL rtype_cycle%0d: got %h expected %h", i, obs, ev[i]); n_err++;
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (retired !== 4'd1 || state !== 4'd1) begin
            $display("FAIL rtype_retire: got retired=%0d state=%0d expected 1/1", retired, state);
            n_err++;
        end
    endtask

    task automatic test_lw_wait();
        logic [20:0] ev [7];
        logic        rdy [7];
        ev  = '{V_FETCH_RDY, V_DECODE, V_MEMADR_LW, V_MEMREAD, V_MEMREAD, V_MEMREAD, V_MEMWB};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = OP_LW;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            #1;
            n_cmp++;
            if (obs !== ev[i]) begin
                $display("FAIL lw_cycle%0d: got %h expected %h", i, obs, ev[i]); n_err++;
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (retired !== 4'd2 || state !== 4'd1) begin
            $display("FAIL lw_retire: got retired=%0d state=%0d expected 2/1", retired, state);
            n_err++;
        end
    endtask

    task automatic test_sw();
        logic [20:0] ev [6];
        logic        rdy [6];
        ev  = '{V_FETCH_WAIT, V_FETCH_RDY, V_DECODE, V_MEMADR_SW, V_MEMWRITE, V_MEMWRITE};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        op = OP_SW;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            n_cmp++;
            if (obs !== ev[i]) begin
                $display("FAIL sw_cycle%0d: got %h expected %h", i, obs, ev[i]); n_err++;
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (retired !== 4'd3 || state !== 4'd1) begin
            $display("FAIL sw_retire: got retired=%0d state=%0d expected 3/1", retired, state);
            n_err++;
        end
    endtask

    task automatic test_beq();
        logic [20:0] ev [3];
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            ev = '{V_FETCH_RDY, V_DECODE, (k == 0) ? V_BEQ_T : V_BEQ_N};
            op = OP_BEQ; mem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                n_cmp++;
                if (obs !== ev[i]) begin
                    $display("FAIL beq%0d_cycle%0d: got %h expected %h", k, i, obs, ev[i]); n_err++;
                end
                @(negedge clk);
            end
            #1;
            n_cmp++;
            if (retired !== 4'(4 + k)) begin
                $display("FAIL beq%0d_retire: got %0d expected %0d", k, retired, 4 + k); n_err++;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        op = OP_BAD; mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== V_FETCH_RDY) begin
            $display("FAIL illegal_fetch: got %h expected %h", obs, V_FETCH_RDY); n_err++;
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== V_DECODE_ILL) begin
            $display("FAIL illegal_decode: got %h expected %h", obs, V_DECODE_ILL); n_err++;
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== V_FETCH_RDY) begin
            $display("FAIL illegal_next: got %h expected %h", obs, V_FETCH_RDY); n_err++;
        end
        n_cmp++;
        if (retired !== 4'd5) begin
            $display("FAIL illegal_retired: got %0d expected 5", retired); n_err++;
        end
    endtask

    task automatic run_rtype();
        op = OP_R; mem_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) run_rtype();
        #1;
        n_cmp++;
        if (retired !== 4'd15) begin
            $display("FAIL wrap_all_ones: got %0d expected 15", retired); n_err++;
        end
        run_rtype();
        #1;
        n_cmp++;
        if (retired !== 4'd0) begin
            $display("FAIL wrap_to_zero: got %0d expected 0", retired); n_err++;
        end
    endtask

    task automatic test_abort();
        op = OP_LW; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== V_MEMREAD) begin
            $display("FAIL abort_in_memread: got %h expected %h", obs, V_MEMREAD); n_err++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== V_IDLE) begin
            $display("FAIL abort_async: got %h expected %h", obs, V_IDLE); n_err++;
        end
        n_cmp++;
        if (retired !== 4'd0) begin
            $display("FAIL abort_retired: got %0d expected 0", retired); n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== V_FETCH_WAIT) begin
            $display("FAIL abort_refetch: got %h expected %h", obs, V_FETCH_WAIT); n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_beq();
        test_illegal();
        test_wrap();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
